// File: rtl/event_sync_hub.sv
// event_sync_hub: multi-channel trigger/wait event synchronizer.
// Each channel counts trigger pulses and serves a wait request/ack handshake.
// Waits use edge semantics (only triggers after arming count) or, when
// EVENT_SYNC_PERSIST_EN is defined and mode_i is set, persistent semantics
// (a pending or same-cycle trigger satisfies the wait immediately).
// Without EVENT_SYNC_PERSIST_EN every channel uses edge semantics; the
// pending counters still count and saturate, and are cleared on arm.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   trig_i       per-channel single-cycle trigger pulse
//   mode_i       per-channel wait semantics (0 edge, 1 persistent), sampled on arm
//   wait_req_i   per-channel wait request, held until ack
//   clr_i        synchronous clear of all channels (highest priority)
//   wait_ack_o   per-channel one-cycle acknowledge
//   pend_cnt_o   per-channel saturating pending count, channel c at [c*CNT_W +: CNT_W]
//   busy_o       channel is waiting
//   ovf_o        sticky, a trigger was lost to counter saturation
module event_sync_hub #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       trig_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]       wait_req_i,
  input  logic                    clr_i,
  output logic [NUM_CH-1:0]       wait_ack_o,
  output logic [NUM_CH*CNT_W-1:0] pend_cnt_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] ack_q, busy_q;
  logic [NUM_CH-1:0] cnt_inc;
  logic [NUM_CH-1:0] persist;

  // Effective wait semantics per channel
`ifdef EVENT_SYNC_PERSIST_EN
  assign persist = mode_i;
`else
  logic unused_mode;
  assign unused_mode = ^mode_i;
  assign persist     = '0;
`endif

  // Next-state, counter and overflow logic for all channels
  always_comb begin
    cnt_inc = '0;
    ovf_d   = ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      unique case (state_q[c])
        S_IDLE: begin
          if (wait_req_i[c]) begin
            if (persist[c]) begin
              // Same-cycle trigger is consumed first, pending count only otherwise
              if (trig_i[c]) begin
                state_d[c] = S_ACK;
              end else if (cnt_q[c] != '0) begin
                cnt_d[c]   = cnt_q[c] - CNT_W'(1);
                state_d[c] = S_ACK;
              end else begin
                state_d[c] = S_WAIT;
              end
            end else begin
              // Edge arm discards history and any same-cycle trigger
              cnt_d[c]   = '0;
              state_d[c] = S_WAIT;
            end
          end else begin
            cnt_inc[c] = trig_i[c];
          end
        end
        S_WAIT: begin
          if (trig_i[c]) begin
            state_d[c] = S_ACK;
          end else if (!wait_req_i[c]) begin
            state_d[c] = S_IDLE;
          end
        end
        S_ACK: begin
          state_d[c] = S_IDLE;
          cnt_inc[c] = trig_i[c];
        end
        default: state_d[c] = S_IDLE;
      endcase

      // Saturating count; a trigger at saturation is flagged, not counted
      if (cnt_inc[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          ovf_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end

      if (clr_i) begin
        state_d[c] = S_IDLE;
        cnt_d[c]   = '0;
        ovf_d[c]   = 1'b0;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
      end
      ovf_q  <= '0;
      ack_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        ack_q[c]   <= (state_d[c] == S_ACK);
        busy_q[c]  <= (state_d[c] == S_WAIT);
      end
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign pend_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign wait_ack_o = ack_q;
  assign busy_o     = busy_q;
  assign ovf_o      = ovf_q;

endmodule
